// File: rtl/eeprom_cmd_ctrl.sv
// eeprom_cmd_ctrl: parses 'W'/'R' command frames from the UART byte link and
// issues one-cycle write/read requests to the 93LC46 SPI engine. Writes are
// paced by a fixed programming-time wait. Reads wait for completion with a
// timeout, then return one byte to the UART transmitter via valid/ready.
// Optional build macro EEPROM_CMD_WR_ACK_EN: return 0x4B after every write.
module eeprom_cmd_ctrl #(
  parameter int unsigned WR_WAIT    = 250000,
  parameter int unsigned RD_TIMEOUT = 4095
) (
  input  logic       clkin,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       spi_write,
  output logic       spi_read,
  output logic [7:0] spi_addr,
  output logic [7:0] spi_data,
  input  logic       spi_rd_done,
  input  logic [7:0] spi_rd_data,
  output logic       busy,
  output logic       err
);

  localparam logic [7:0] CMD_WR     = 8'h57;
  localparam logic [7:0] CMD_RD     = 8'h52;
  localparam logic [7:0] RD_TO_BYTE = 8'hEE;
`ifdef EEPROM_CMD_WR_ACK_EN
  localparam logic [7:0] WR_ACK_BYTE = 8'h4B;
`endif

  localparam int unsigned CNT_MAX = (WR_WAIT > RD_TIMEOUT) ? WR_WAIT : RD_TIMEOUT;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] WR_LAST = CNT_W'(WR_WAIT - 1);
  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(RD_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_GET_ADDR, S_GET_DATA, S_ISSUE_WR,
    S_WAIT_WR, S_ISSUE_RD, S_WAIT_RD, S_SEND
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_wr_flag;
  logic             w_wr_flag_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic             w_cnt_clr;
  logic             w_addr_ld;
  logic             w_data_ld;
  logic             w_tx_ld;
  logic [7:0]       w_tx_nxt;
  logic             w_err_nxt;

  logic [7:0] r_tx_data;
  logic       r_tx_valid;
  logic       r_spi_write;
  logic       r_spi_read;
  logic [7:0] r_spi_addr;
  logic [7:0] r_spi_data;
  logic       r_busy;
  logic       r_err;

  // State register and command-type flag
  always_ff @(posedge clkin) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_wr_flag <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_wr_flag <= w_wr_flag_nxt;
    end
  end

  // Next-state decode plus load strobes for the datapath registers
  always_comb begin
    w_state_nxt   = r_state;
    w_wr_flag_nxt = r_wr_flag;
    w_cnt_clr     = 1'b0;
    w_addr_ld     = 1'b0;
    w_data_ld     = 1'b0;
    w_tx_ld       = 1'b0;
    w_tx_nxt      = r_tx_data;
    w_err_nxt     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (rx_valid) begin
          if (rx_data == CMD_WR) begin
            w_state_nxt   = S_GET_ADDR;
            w_wr_flag_nxt = 1'b1;
          end else if (rx_data == CMD_RD) begin
            w_state_nxt   = S_GET_ADDR;
            w_wr_flag_nxt = 1'b0;
          end else begin
            w_err_nxt = 1'b1;
          end
        end
      end
      S_GET_ADDR: begin
        if (rx_valid) begin
          w_addr_ld   = 1'b1;
          w_state_nxt = r_wr_flag ? S_GET_DATA : S_ISSUE_RD;
        end
      end
      S_GET_DATA: begin
        if (rx_valid) begin
          w_data_ld   = 1'b1;
          w_state_nxt = S_ISSUE_WR;
        end
      end
      S_ISSUE_WR: begin
        w_err_nxt   = rx_valid;
        w_cnt_clr   = 1'b1;
        w_state_nxt = S_WAIT_WR;
      end
      S_WAIT_WR: begin
        w_err_nxt = rx_valid;
        if (r_cnt == WR_LAST) begin
`ifdef EEPROM_CMD_WR_ACK_EN
          w_state_nxt = S_SEND;
          w_tx_ld     = 1'b1;
          w_tx_nxt    = WR_ACK_BYTE;
`else
          w_state_nxt = S_IDLE;
`endif
        end
      end
      S_ISSUE_RD: begin
        w_err_nxt   = rx_valid;
        w_cnt_clr   = 1'b1;
        w_state_nxt = S_WAIT_RD;
      end
      S_WAIT_RD: begin
        w_err_nxt = rx_valid;
        // A completion landing on the timeout cycle still counts as success
        if (spi_rd_done) begin
          w_state_nxt = S_SEND;
          w_tx_ld     = 1'b1;
          w_tx_nxt    = spi_rd_data;
        end else if (r_cnt == RD_LAST) begin
          w_state_nxt = S_SEND;
          w_tx_ld     = 1'b1;
          w_tx_nxt    = RD_TO_BYTE;
          w_err_nxt   = 1'b1;
        end
      end
      S_SEND: begin
        w_err_nxt = rx_valid;
        if (r_tx_valid && tx_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Wait counter: cleared in the issue cycle, saturating count in wait states
  always_ff @(posedge clkin) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (w_cnt_clr) begin
      r_cnt <= '0;
    end else if ((r_state == S_WAIT_WR || r_state == S_WAIT_RD) && r_cnt != '1) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Registered outputs, derived from the upcoming state so they align with it
  always_ff @(posedge clkin) begin
    if (reset) begin
      r_tx_data   <= '0;
      r_tx_valid  <= 1'b0;
      r_spi_write <= 1'b0;
      r_spi_read  <= 1'b0;
      r_spi_addr  <= '0;
      r_spi_data  <= '0;
      r_busy      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      if (w_tx_ld)   r_tx_data  <= w_tx_nxt;
      if (w_addr_ld) r_spi_addr <= rx_data;
      if (w_data_ld) r_spi_data <= rx_data;
      r_tx_valid  <= (w_state_nxt == S_SEND);
      r_spi_write <= (w_state_nxt == S_ISSUE_WR);
      r_spi_read  <= (w_state_nxt == S_ISSUE_RD);
      r_busy      <= (w_state_nxt != S_IDLE);
      r_err       <= w_err_nxt;
    end
  end

  assign tx_data   = r_tx_data;
  assign tx_valid  = r_tx_valid;
  assign spi_write = r_spi_write;
  assign spi_read  = r_spi_read;
  assign spi_addr  = r_spi_addr;
  assign spi_data  = r_spi_data;
  assign busy      = r_busy;
  assign err       = r_err;

endmodule

// File: tb/tb_eeprom_cmd_ctrl.sv
// Bench for eeprom_cmd_ctrl. The model is a per-cycle timeline of expected
// outputs, filled by the stimulus tasks from the frame timing rules; a single
// negedge process compares every output every cycle, plus literal pins.
module tb_eeprom_cmd_ctrl;

  localparam int WR_WAIT_TB = 16;
  localparam int RD_TO_TB   = 64;
  localparam int NCYC       = 1024;
  localparam int LAST       = NCYC - 1;
  localparam int NSIG       = 8;
  localparam int TXD = 0, TXV = 1, WR = 2, RD = 3, ADR = 4, DAT = 5, BSY = 6, ERR = 7;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       spi_write;
  logic       spi_read;
  logic [7:0] spi_addr;
  logic [7:0] spi_data;
  logic       spi_rd_done;
  logic [7:0] spi_rd_data;
  logic       busy;
  logic       err;

  eeprom_cmd_ctrl #(.WR_WAIT(WR_WAIT_TB), .RD_TIMEOUT(RD_TO_TB)) dut (
    .clkin(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .spi_write(spi_write), .spi_read(spi_read), .spi_addr(spi_addr),
    .spi_data(spi_data), .spi_rd_done(spi_rd_done), .spi_rd_data(spi_rd_data),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] exp_v [NSIG][NCYC];

  typedef struct { int c; int s; logic [7:0] v; } pin_t;
  pin_t pins[$];
  bit   tb_done = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  function automatic string sig_name(input int s);
    case (s)
      TXD: return "tx_data";
      TXV: return "tx_valid";
      WR:  return "spi_write";
      RD:  return "spi_read";
      ADR: return "spi_addr";
      DAT: return "spi_data";
      BSY: return "busy";
      default: return "err";
    endcase
  endfunction

  task automatic fill(input int s, input int from, input int to, input logic [7:0] v);
    for (int t = from; t <= to && t < NCYC; t++) exp_v[s][t] = v;
  endtask

  task automatic pin(input int c, input int s, input logic [7:0] v);
    pins.push_back('{c, s, v});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    rx_valid    = 1'b0;
    spi_rd_done = 1'b0;
    tx_ready    = 1'b0;
    spi_rd_data = 8'($urandom_range(0, 255));
  endtask

  task automatic goto(input int t);
    while (cyc < t) step();
  endtask

  // Write frame: cmd at c, addr at c+1, data at n=c+2; spi_write at n+1,
  // WAIT_WR covers n+2 .. n+1+WR_WAIT.
  task automatic write_frame(input logic [7:0] a, input logic [7:0] d, input bit ovr);
    int c, n, s, idle;
    c = cyc + 1;
    n = c + 2;
    s = n + 2 + WR_WAIT_TB;
`ifdef EEPROM_CMD_WR_ACK_EN
    idle = s + 1;
    fill(TXV, s, s, 8'h01);
    fill(TXD, s, LAST, 8'h4B);
`else
    idle = s;
`endif
    fill(BSY, c + 1, idle - 1, 8'h01);
    fill(ADR, c + 2, LAST, a);
    fill(DAT, n + 1, LAST, d);
    fill(WR, n + 1, n + 1, 8'h01);
    if (ovr) fill(ERR, n + 6, n + 6, 8'h01);
    step(); rx_valid = 1'b1; rx_data = 8'h57;
    step(); rx_valid = 1'b1; rx_data = a;
    step(); rx_valid = 1'b1; rx_data = d;
    if (ovr) begin
      goto(n + 5);
      rx_valid = 1'b1; rx_data = 8'hFF;
    end
    goto(idle - 1);
`ifdef EEPROM_CMD_WR_ACK_EN
    tx_ready = 1'b1;
`endif
  endtask

  // Read frame: cmd at c, addr at n=c+1, spi_read at n+1, WAIT_RD from n+2.
  // d<0: no completion (timeout); else spi_rd_done at n+1+d.
  task automatic read_frame(input logic [7:0] a, input int d, input logic [7:0] rd,
                            input int hold);
    int c, n, m, ss, k;
    logic [7:0] txd;
    c = cyc + 1;
    n = c + 1;
    m = 0;
    if (d >= 0) begin
      m   = n + 1 + d;
      ss  = m + 1;
      txd = rd;
    end else begin
      ss  = n + 2 + RD_TO_TB;
      txd = 8'hEE;
      fill(ERR, ss, ss, 8'h01);
    end
    k = ss + hold;
    fill(BSY, c + 1, k, 8'h01);
    fill(ADR, n + 1, LAST, a);
    fill(RD, n + 1, n + 1, 8'h01);
    fill(TXV, ss, k, 8'h01);
    fill(TXD, ss, LAST, txd);
    step(); rx_valid = 1'b1; rx_data = 8'h52;
    step(); rx_valid = 1'b1; rx_data = a;
    if (d >= 0) begin
      goto(m);
      spi_rd_done = 1'b1; spi_rd_data = rd;
    end
    goto(k);
    tx_ready = 1'b1;
  endtask

  int n_wr = 0, n_rd = 0, n_errp = 0, n_hs = 0, n_pin_hits = 0;

  // Single compare process: timeline model, literal pins, final totals
  always @(negedge clk) begin
    logic [7:0] got [NSIG];
    if (cyc >= 1 && cyc < NCYC) begin
      got[TXD] = tx_data;
      got[TXV] = {7'd0, tx_valid};
      got[WR]  = {7'd0, spi_write};
      got[RD]  = {7'd0, spi_read};
      got[ADR] = spi_addr;
      got[DAT] = spi_data;
      got[BSY] = {7'd0, busy};
      got[ERR] = {7'd0, err};
      for (int s = 0; s < NSIG; s++) begin
        n_checks++;
        if (got[s] !== exp_v[s][cyc]) begin
          n_errors++;
          $display("FAIL model_%s cyc=%0d got=%h exp=%h", sig_name(s), cyc, got[s], exp_v[s][cyc]);
        end
      end
      foreach (pins[i]) begin
        if (pins[i].c == cyc) begin
          n_pin_hits++;
          n_checks++;
          if (got[pins[i].s] !== pins[i].v) begin
            n_errors++;
            $display("FAIL pin_%s cyc=%0d got=%h exp=%h", sig_name(pins[i].s), cyc,
                     got[pins[i].s], pins[i].v);
          end
        end
      end
      if (spi_write === 1'b1) n_wr++;
      if (spi_read === 1'b1) n_rd++;
      if (err === 1'b1) n_errp++;
      if (tx_valid === 1'b1 && tx_ready === 1'b1) n_hs++;
    end
    if (tb_done || cyc >= NCYC - 2) begin
      n_checks++;
      if (!tb_done) begin
        n_errors++;
        $display("FAIL watchdog cyc=%0d got=timeout exp=done", cyc);
      end
      n_checks++;
      if (n_pin_hits != pins.size()) begin
        n_errors++;
        $display("FAIL pins_hit got=%0d exp=%0d", n_pin_hits, pins.size());
      end
      n_checks++;
      if (n_wr != 2) begin n_errors++; $display("FAIL write_pulses got=%0d exp=2", n_wr); end
      n_checks++;
      if (n_rd != 4) begin n_errors++; $display("FAIL read_pulses got=%0d exp=4", n_rd); end
      n_checks++;
      if (n_errp != 4) begin n_errors++; $display("FAIL err_pulses got=%0d exp=4", n_errp); end
      n_checks++;
`ifdef EEPROM_CMD_WR_ACK_EN
      if (n_hs != 6) begin n_errors++; $display("FAIL handshakes got=%0d exp=6", n_hs); end
`else
      if (n_hs != 4) begin n_errors++; $display("FAIL handshakes got=%0d exp=4", n_hs); end
`endif
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
    end
  end

  initial begin
    int n, c;
    for (int s = 0; s < NSIG; s++)
      for (int t = 0; t < NCYC; t++) exp_v[s][t] = 8'h00;
    reset = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; tx_ready = 1'b0;
    spi_rd_done = 1'b0; spi_rd_data = 8'h00;
    for (int s = 0; s < NSIG; s++) pin(2, s, 8'h00);
    step(); step(); step();
    reset = 1'b0;

    // Write 0x05/0xA3 with a stray byte during WAIT_WR
    n = cyc + 3;
    pin(n + 1, WR, 8'h01); pin(n + 1, ADR, 8'h05); pin(n + 1, DAT, 8'hA3);
    pin(n + 6, ERR, 8'h01); pin(n + 17, BSY, 8'h01); pin(n + 2, WR, 8'h00);
`ifdef EEPROM_CMD_WR_ACK_EN
    pin(n + 18, TXV, 8'h01); pin(n + 18, TXD, 8'h4B); pin(n + 19, BSY, 8'h00);
`else
    pin(n + 18, BSY, 8'h00); pin(n + 18, TXV, 8'h00);
`endif
    write_frame(8'h05, 8'hA3, 1'b1);
    step(); step();

    // Invalid command byte
    c = cyc + 1;
    pin(c + 1, ERR, 8'h01); pin(c + 1, BSY, 8'h00);
    fill(ERR, c + 1, c + 1, 8'h01);
    step(); rx_valid = 1'b1; rx_data = 8'h41;
    step(); step();

    // Completion strobe while idle must be ignored
    step(); spi_rd_done = 1'b1; spi_rd_data = 8'h77;
    step(); step();

    // Read 0x12: done 30 cycles after request, tx_ready held low 5 cycles
    n = cyc + 2;
    pin(n + 1, RD, 8'h01); pin(n + 1, ADR, 8'h12); pin(n + 31, TXV, 8'h00);
    pin(n + 32, TXV, 8'h01); pin(n + 32, TXD, 8'h3C); pin(n + 36, TXD, 8'h3C);
    pin(n + 37, TXV, 8'h01); pin(n + 38, TXV, 8'h00); pin(n + 38, BSY, 8'h00);
    read_frame(8'h12, 30, 8'h3C, 5);
    step(); step();

    // Read 0x01 with no completion: timeout
    n = cyc + 2;
    pin(n + 65, ERR, 8'h00); pin(n + 65, TXV, 8'h00); pin(n + 66, ERR, 8'h01);
    pin(n + 66, TXD, 8'hEE); pin(n + 66, TXV, 8'h01); pin(n + 67, ERR, 8'h00);
    pin(n + 67, BSY, 8'h00);
    read_frame(8'h01, -1, 8'h00, 0);
    step(); step();

    // Read 0x80: completion on the last counted cycle beats the timeout
    n = cyc + 2;
    pin(n + 1, ADR, 8'h80); pin(n + 66, ERR, 8'h00); pin(n + 66, TXD, 8'hC5);
    pin(n + 66, TXV, 8'h01); pin(n + 68, TXV, 8'h01); pin(n + 69, TXV, 8'h00);
    read_frame(8'h80, 64, 8'hC5, 2);
    step(); step();

    // Back-to-back: write then read with command on the first idle cycle
    n = cyc + 3;
    pin(n + 1, WR, 8'h01); pin(n + 1, DAT, 8'h5A); pin(n + 1, ADR, 8'h7F);
    write_frame(8'h7F, 8'h5A, 1'b0);
    c = cyc + 1;
    pin(c, BSY, 8'h00); pin(c + 1, BSY, 8'h01);
    n = cyc + 2;
    pin(n + 1, RD, 8'h01); pin(n + 1, ADR, 8'h33); pin(n + 4, TXV, 8'h00);
    pin(n + 5, TXV, 8'h01); pin(n + 5, TXD, 8'h96); pin(n + 1, DAT, 8'h5A);
    read_frame(8'h33, 3, 8'h96, 0);
    step(); step();

    // Reset in the middle of a write frame, then an invalid byte
    c = cyc + 1;
    fill(BSY, c + 1, c + 2, 8'h01);
    fill(ADR, c + 2, LAST, 8'h07);
    fill(ADR, c + 3, LAST, 8'h00);
    fill(DAT, c + 3, LAST, 8'h00);
    fill(TXD, c + 3, LAST, 8'h00);
    fill(ERR, c + 4, c + 4, 8'h01);
    pin(c + 2, ADR, 8'h07); pin(c + 3, ADR, 8'h00); pin(c + 3, BSY, 8'h00);
    pin(c + 3, WR, 8'h00); pin(c + 4, ERR, 8'h01); pin(c + 4, BSY, 8'h00);
    step(); rx_valid = 1'b1; rx_data = 8'h57;
    step(); rx_valid = 1'b1; rx_data = 8'h07;
    step(); reset = 1'b1;
    step(); reset = 1'b0; rx_valid = 1'b1; rx_data = 8'h99;
    goto(cyc + 4);
    tb_done = 1'b1;
  end

endmodule
